alu_unit: RTL and testbench

Execution unit that consumes the 4-bit `alu_ctrl` code produced by the ALU controller, together with two operands, and returns a 32-bit result over a valid/ready handshake. Logic, arithmetic and compare operations finish in one cycle. Shifts are either iterative, one bit per cycle, or single-cycle, selected at compile time. The block sits in the execute stage between the register-read operands and the writeback path.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_shifter.sv | 73 +++++++
 rtl/alu_unit.sv | 119 +++++++++++
 tb/tb_alu_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: alu_ctrl opcodes (also used by the ALU controller),
// FSM state encoding and default data width.
package alu_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;

   // alu_ctrl = {funct7[5], funct3}
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_t;

   typedef enum logic [1:0] {
      SHIFT_LL = 2'd0,
      SHIFT_RL = 2'd1,
      SHIFT_RA = 2'd2
   } shift_kind_t;

   function automatic logic is_shift_op(input logic [3:0] ctrl);
      return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
   endfunction

   function automatic shift_kind_t shift_kind_of(input logic [3:0] ctrl);
      shift_kind_t kind;
      case (ctrl)
         ALU_SLL: kind = SHIFT_LL;
         ALU_SRA: kind = SHIFT_RA;
         default: kind = SHIFT_RL;
      endcase
      return kind;
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift datapath for alu_unit: one bit per cycle with a down-counter, or a
// combinational barrel shifter when ALU_UNIT_FAST_SHIFT_EN is defined.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_DATA_WIDTH,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  shift_kind_t            kind,
   input  logic [WIDTH-1:0]       operand,
   input  logic [SHAMT_WIDTH-1:0] shamt,
   output logic [WIDTH-1:0]       step_result,
   output logic                   last_step
);

`ifdef ALU_UNIT_FAST_SHIFT_EN

   logic unused_ok;
   assign unused_ok = &{1'b0, clk, reset, start};

   always_comb begin
      case (kind)
         SHIFT_LL: step_result = operand << shamt;
         SHIFT_RA: step_result = WIDTH'($signed(operand) >>> shamt);
         default:  step_result = operand >> shamt;
      endcase
   end

   assign last_step = 1'b1;

`else

   logic [WIDTH-1:0]       work_q;
   logic [SHAMT_WIDTH-1:0] count_q;
   shift_kind_t            kind_q;
   logic [WIDTH-1:0]       step_src;
   shift_kind_t            step_kind;

   // The accept cycle already performs the first one-bit step on the live
   // operand, so a shift by N finishes after N steps with no extra cycle.
   always_comb begin
      step_src  = start ? operand : work_q;
      step_kind = start ? kind : kind_q;
      case (step_kind)
         SHIFT_LL: step_result = {step_src[WIDTH-2:0], 1'b0};
         SHIFT_RA: step_result = {step_src[WIDTH-1], step_src[WIDTH-1:1]};
         default:  step_result = {1'b0, step_src[WIDTH-1:1]};
      endcase
   end

   assign last_step = start ? (shamt == SHAMT_WIDTH'(1)) : (count_q == SHAMT_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         work_q  <= '0;
         count_q <= '0;
         kind_q  <= SHIFT_LL;
      end else if (start) begin
         work_q  <= step_result;
         count_q <= shamt - SHAMT_WIDTH'(1);
         kind_q  <= kind;
      end else if (count_q != '0) begin
         work_q  <= step_result;
         count_q <= count_q - SHAMT_WIDTH'(1);
      end
   end

`endif

endmodule

// File: rtl/alu_unit.sv
// Execute-stage ALU with valid/ready handshake. Shifts are iterative unless
// ALU_UNIT_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_unit
   import alu_pkg::*;
#(
   parameter int REG_DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int SHAMT_WIDTH    = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [3:0]                alu_ctrl,
   input  logic [REG_DATA_WIDTH-1:0] op_a,
   input  logic [REG_DATA_WIDTH-1:0] op_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [REG_DATA_WIDTH-1:0] result,
   output logic                      zero
);

   alu_state_t                state_q, state_d;
   logic [REG_DATA_WIDTH-1:0] result_q;
   logic [REG_DATA_WIDTH-1:0] single_result;
   logic [REG_DATA_WIDTH-1:0] shift_result;
   logic [SHAMT_WIDTH-1:0]    shamt;
   shift_kind_t               kind;
   logic                      shift_op;
   logic                      accept;
   logic                      shift_start;
   logic                      last_step;
   logic                      load_single;
   logic                      load_shift;

   assign shamt       = op_b[SHAMT_WIDTH-1:0];
   assign shift_op    = is_shift_op(alu_ctrl);
   assign kind        = shift_kind_of(alu_ctrl);
   assign in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign out_valid   = (state_q == ST_DONE);
   assign accept      = in_valid && in_ready;
   assign shift_start = accept && shift_op && (shamt != '0);

   alu_shifter #(
      .WIDTH       (REG_DATA_WIDTH),
      .SHAMT_WIDTH (SHAMT_WIDTH)
   ) u_shifter (
      .clk         (clk),
      .reset       (reset),
      .start       (shift_start),
      .kind        (kind),
      .operand     (op_a),
      .shamt       (shamt),
      .step_result (shift_result),
      .last_step   (last_step)
   );

   // A shift by zero is just op_a, so it shares the single-cycle path.
   always_comb begin
      single_result = '0;
      case (alu_ctrl)
         ALU_ADD:  single_result = op_a + op_b;
         ALU_SUB:  single_result = op_a - op_b;
         ALU_SLT:  single_result[0] = $signed(op_a) < $signed(op_b);
         ALU_SLTU: single_result[0] = op_a < op_b;
         ALU_XOR:  single_result = op_a ^ op_b;
         ALU_OR:   single_result = op_a | op_b;
         ALU_AND:  single_result = op_a & op_b;
         ALU_SLL, ALU_SRL, ALU_SRA: single_result = op_a;
         default:  single_result = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      load_single = 1'b0;
      load_shift  = 1'b0;
      case (state_q)
         ST_IDLE: ;
         ST_SHIFT: begin
            if (last_step) begin
               load_shift = 1'b1;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready && !in_valid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept) begin
         if (shift_start) begin
            if (last_step) begin
               load_shift = 1'b1;
               state_d    = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end else begin
            load_single = 1'b1;
            state_d     = ST_DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (load_single) result_q <= single_result;
         else if (load_shift) result_q <= shift_result;
      end
   end

   assign result = result_q;
   assign zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: table of directed vectors plus hand-written
// handshake, backpressure and reset-during-shift sequences.
module tb_alu_unit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;

   int test_count = 0;
   int fail_count = 0;

   typedef struct {
      string       name;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_result;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   alu_unit #(
      .REG_DATA_WIDTH (32),
      .SHAMT_WIDTH    (5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int shift_lat(input int n);
`ifdef ALU_UNIT_FAST_SHIFT_EN
      return 1;
`else
      return (n < 1) ? 1 : n;
`endif
   endfunction

   function automatic vec_t mk(input string name, input logic [3:0] ctrl,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_result, input int lat);
      vec_t v;
      v.name       = name;
      v.ctrl       = ctrl;
      v.a          = a;
      v.b          = b;
      v.exp_result = exp_result;
      v.lat        = lat;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Called #1 after a rising edge with the unit idle; returns the number of
   // cycles from accept until out_valid is seen (accept cycle counts as 1).
   task automatic applyStimulus(input vec_t v, output int lat, output bit busy_ready);
      in_valid = 1'b1;
      alu_ctrl = v.ctrl;
      op_a     = v.a;
      op_b     = v.b;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      alu_ctrl   = 4'b0111;
      op_a       = ~v.a;
      op_b       = v.b ^ 32'h0000_001F;
      lat        = 1;
      busy_ready = 1'b0;
      while (!out_valid && lat < 64) begin
         if (in_ready) busy_ready = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat;
      bit busy;
      bit seen;

      vecs.push_back(mk("add",       4'b0000, 32'd5,        32'd7,        32'd12,       1));
      vecs.push_back(mk("sub",       4'b1000, 32'd3,        32'd5,        32'hFFFFFFFE, 1));
      vecs.push_back(mk("slt",       4'b0010, 32'hFFFFFFFF, 32'd1,        32'd1,        1));
      vecs.push_back(mk("sltu",      4'b0011, 32'hFFFFFFFF, 32'd1,        32'd0,        1));
      vecs.push_back(mk("xor",       4'b0100, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd0,        1));
      vecs.push_back(mk("or",        4'b0110, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1));
      vecs.push_back(mk("and",       4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1));
      vecs.push_back(mk("add_wrap",  4'b0000, 32'hFFFFFFFF, 32'd1,        32'd0,        1));
      vecs.push_back(mk("sra4",      4'b1101, 32'h80000000, 32'h00000024, 32'hF8000000, shift_lat(4)));
      vecs.push_back(mk("srl4",      4'b0101, 32'h80000000, 32'd4,        32'h08000000, shift_lat(4)));
      vecs.push_back(mk("sra3_pos",  4'b1101, 32'h7FFFFFFF, 32'hFFFFFFE3, 32'h0FFFFFFF, shift_lat(3)));
      vecs.push_back(mk("sra1",      4'b1101, 32'h80000001, 32'd1,        32'hC0000000, shift_lat(1)));
      vecs.push_back(mk("sll31",     4'b0001, 32'd1,        32'd31,       32'h80000000, shift_lat(31)));
      vecs.push_back(mk("sll0",      4'b0001, 32'h00001234, 32'h00000020, 32'h00001234, 1));
      vecs.push_back(mk("code1111",  4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1));
      vecs.push_back(mk("code1001",  4'b1001, 32'd3,        32'd5,        32'd0,        1));

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      alu_ctrl  = 4'b0000;
      op_a      = '0;
      op_b      = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset/in_ready",  32'(in_ready),  32'd1);
      checkOutput("reset/out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset/result",    result,         32'd0);
      checkOutput("reset/zero",      32'(zero),      32'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], lat, busy);
         checkOutput({vecs[i].name, "/result"},  result,      vecs[i].exp_result);
         checkOutput({vecs[i].name, "/zero"},    32'(zero),   32'(vecs[i].exp_result == 32'd0));
         checkOutput({vecs[i].name, "/latency"}, 32'(lat),    32'(vecs[i].lat));
         if (vecs[i].lat > 1) checkOutput({vecs[i].name, "/busy_in_ready"}, 32'(busy), 32'd0);
         @(posedge clk);
         #1;
         checkOutput({vecs[i].name, "/drained"}, 32'(out_valid), 32'd0);
      end

      // Back-to-back single-cycle ops with out_ready high: one result per cycle.
      in_valid = 1'b1;
      alu_ctrl = 4'b0000; op_a = 32'd1;  op_b = 32'd1;
      @(posedge clk); #1;
      checkOutput("b2b/first", result, 32'd2);
      alu_ctrl = 4'b1000; op_a = 32'd10; op_b = 32'd4;
      @(posedge clk); #1;
      checkOutput("b2b/second", result, 32'd6);
      checkOutput("b2b/second_valid", 32'(out_valid), 32'd1);
      alu_ctrl = 4'b0100; op_a = 32'hF;  op_b = 32'h3;
      @(posedge clk); #1;
      checkOutput("b2b/third", result, 32'hC);
      in_valid = 1'b0;
      @(posedge clk); #1;

      // Backpressure: result held while out_ready is low, then overlapped handoff.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      alu_ctrl  = 4'b0000; op_a = 32'h10; op_b = 32'h20;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op_a     = 32'hDEAD;
      for (int c = 0; c < 3; c++) begin
         checkOutput("bp/result_stable", result, 32'h30);
         checkOutput("bp/in_ready_low", 32'(in_ready), 32'd0);
         checkOutput("bp/out_valid", 32'(out_valid), 32'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      alu_ctrl  = 4'b0110; op_a = 32'hF0; op_b = 32'h0F;
      #1;
      checkOutput("bp/in_ready_follows", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("bp/no_bubble_valid", 32'(out_valid), 32'd1);
      checkOutput("bp/no_bubble_result", result, 32'hFF);
      @(posedge clk); #1;

      // A held request during a shift is ignored until the shift result is taken.
      in_valid = 1'b1;
      alu_ctrl = 4'b0101; op_a = 32'h100; op_b = 32'd8;
      @(posedge clk); #1;
      alu_ctrl = 4'b0000; op_a = 32'd1; op_b = 32'd2;
      lat = 1;
      while (!out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("held/shift_result", result, 32'h1);
      checkOutput("held/shift_latency", 32'(lat), 32'(shift_lat(8)));
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("held/next_result", result, 32'd3);
      checkOutput("held/next_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;

      // Reset in the middle of a long shift discards it.
      in_valid = 1'b1;
      alu_ctrl = 4'b0001; op_a = 32'd1; op_b = 32'd31;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("rst_shift/out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_shift/result",    result,         32'd0);
      checkOutput("rst_shift/in_ready",  32'(in_ready),  32'd1);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      checkOutput("rst_shift/no_result", 32'(seen), 32'd0);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
